// File: rtl/bist_misr_checker.sv
// bist_misr_checker: response-analysis end of the on-chip BIST loop.
// Compacts CUT response words into a MISR while the run strobe is high.
// The feedback taps are chosen by the controller's polynomial-select line.
// On the finish pulse, the signature is compared against GOLDEN.
// PASS/FAIL are then held until the controller leaves end-of-test.
// Optional feature macro: BIST_CHK_COUNT_EN. When defined, a saturating
// vector counter is built and PASS also requires VEC_COUNT == EXP_VECS.
// When undefined, VEC_COUNT is tied to 0.
module bist_misr_checker #(
  parameter int            W        = 8,
  parameter logic [W-1:0]  POLY_A   = 'h1D,
  parameter logic [W-1:0]  POLY_B   = 'h2B,
  parameter logic [W-1:0]  SIG_INIT = '0,
  parameter logic [W-1:0]  GOLDEN   = 'hA5,
  parameter logic [15:0]   EXP_VECS = 16'd990
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         OUT_I,
  input  logic         POLY_I,
  input  logic         FINISH_I,
  input  logic         BIST_END_I,
  input  logic [W-1:0] CUT_DATA,
  output logic [W-1:0] SIGNATURE,
  output logic         DONE,
  output logic         PASS,
  output logic         FAIL,
  output logic [15:0]  VEC_COUNT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPACT = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] RESULT  = 2'd3;

  logic [1:0]   state;
  logic [W-1:0] taps;
  logic [W-1:0] misr_next;
  logic         step;
  logic         restart;
  logic         match;

  // MISR next-state: shift left, fold in taps on MSB, XOR in the CUT word.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    taps      = POLY_I ? POLY_B : POLY_A;
    misr_next = {SIGNATURE[W-2:0], 1'b0} ^ CUT_DATA;
    if (SIGNATURE[W-1]) misr_next = misr_next ^ taps;
  end

  assign step    = OUT_I && ((state == IDLE) || (state == COMPACT));
  assign restart = (state == RESULT) && !BIST_END_I;

`ifdef BIST_CHK_COUNT_EN
  // Saturating count of compacted words for the current run.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      VEC_COUNT <= '0;
    end else if (restart) begin
      VEC_COUNT <= '0;
    end else if (step && (VEC_COUNT != 16'hFFFF)) begin
      VEC_COUNT <= VEC_COUNT + 16'd1;
    end
  end

  assign match = (SIGNATURE == GOLDEN) && (VEC_COUNT == EXP_VECS);
`else
  assign VEC_COUNT = '0;
  assign match     = (SIGNATURE == GOLDEN);
`endif

  // Run-control FSM with the signature and result registers it owns.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, whatever the statement order.
    if (RESET) begin
      state     <= IDLE;
      SIGNATURE <= SIG_INIT;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      FAIL      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (OUT_I) SIGNATURE <= misr_next;
          if (FINISH_I)   state <= CHECK;
          else if (OUT_I) state <= COMPACT;
        end
        COMPACT: begin
          // A word coincident with FINISH_I is still compacted first.
          if (OUT_I)    SIGNATURE <= misr_next;
          if (FINISH_I) state     <= CHECK;
        end
        CHECK: begin
          DONE  <= 1'b1;
          PASS  <= match;
          FAIL  <= !match;
          state <= RESULT;
        end
        default: begin
          // RESULT: hold everything until the controller leaves end-of-test.
          if (!BIST_END_I) begin
            SIGNATURE <= SIG_INIT;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL      <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_misr_checker.sv
// Self-checking bench for bist_misr_checker.
// Two instances share one stimulus stream: dut_a has GOLDEN=8'h35 and
// dut_b has GOLDEN=8'h5A. Both use EXP_VECS=2.
// The driver pushes the expected outputs after each edge. A separate
// monitor pops them and compares against the sampled DUT outputs.
module tb_bist_misr_checker;

  typedef struct packed {
    logic [7:0]  sig;
    logic        done;
    logic        pass;
    logic        fail;
    logic [15:0] cnt;
  } exp_t;

`ifdef BIST_CHK_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        out_i, poly_i, finish_i, bist_end_i;
  logic [7:0]  cut_data;
  logic [7:0]  sig_a, sig_b;
  logic        done_a, pass_a, fail_a, done_b, pass_b, fail_b;
  logic [15:0] cnt_a, cnt_b;

  exp_t qa[$];
  exp_t qb[$];
  int   tag_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   vec_id      = 0;
  event mon_ev;

  bist_misr_checker #(.W(8), .GOLDEN(8'h35), .EXP_VECS(16'd2)) dut_a (
    .CLK(clk), .RESET(reset), .OUT_I(out_i), .POLY_I(poly_i),
    .FINISH_I(finish_i), .BIST_END_I(bist_end_i), .CUT_DATA(cut_data),
    .SIGNATURE(sig_a), .DONE(done_a), .PASS(pass_a), .FAIL(fail_a),
    .VEC_COUNT(cnt_a)
  );

  bist_misr_checker #(.W(8), .GOLDEN(8'h5A), .EXP_VECS(16'd2)) dut_b (
    .CLK(clk), .RESET(reset), .OUT_I(out_i), .POLY_I(poly_i),
    .FINISH_I(finish_i), .BIST_END_I(bist_end_i), .CUT_DATA(cut_data),
    .SIGNATURE(sig_b), .DONE(done_b), .PASS(pass_b), .FAIL(fail_b),
    .VEC_COUNT(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int id, input exp_t got, input exp_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s vec %0d: got sig=%h done=%b pass=%b fail=%b cnt=%0d, want sig=%h done=%b pass=%b fail=%b cnt=%0d",
               name, id, got.sig, got.done, got.pass, got.fail, got.cnt,
               want.sig, want.done, want.pass, want.fail, want.cnt);
    end
  endtask

  // Monitor: drain pending expectations at each falling edge or on request.
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      while (qa.size() > 0) begin
        exp_t ga, gb;
        int   id;
        ga = '{sig: sig_a, done: done_a, pass: pass_a, fail: fail_a, cnt: cnt_a};
        gb = '{sig: sig_b, done: done_b, pass: pass_b, fail: fail_b, cnt: cnt_b};
        id = tag_q.pop_front();
        check("dut_a", id, ga, qa.pop_front());
        check("dut_b", id, gb, qb.pop_front());
      end
    end
  end

  // Build both expectations. dut_a passes when pa=1; dut_b never passes here.
  task automatic push_exp(input logic [7:0] sig, input logic done, input logic pa,
                          input logic [15:0] cnt);
    logic [15:0] c;
    c = CNT_EN ? cnt : 16'd0;
    qa.push_back('{sig: sig, done: done, pass: done & pa, fail: done & ~pa, cnt: c});
    qb.push_back('{sig: sig, done: done, pass: 1'b0, fail: done, cnt: c});
    tag_q.push_back(vec_id);
    vec_id++;
  endtask

  // One clock cycle: drive inputs, take the edge, then push the expected result.
  task automatic cyc(input logic o, input logic p, input logic f, input logic be,
                     input logic [7:0] d, input logic [7:0] sig, input logic done,
                     input logic pa, input logic [15:0] cnt);
    out_i      = o;
    poly_i     = p;
    finish_i   = f;
    bist_end_i = be;
    cut_data   = d;
    @(posedge clk);
    #1;
    push_exp(sig, done, pa, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    out_i = 1'b0; poly_i = 1'b0; finish_i = 1'b0; bist_end_i = 1'b1; cut_data = 8'h00;
    @(posedge clk);
    #1;
    // Reset values.
    cyc(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    reset = 1'b0;

    // Run 1: two words with a gap, golden match on dut_a.
    cyc(1, 0, 0, 1, 8'h5A, 8'h5A, 0, 0, 1);
    cyc(0, 0, 0, 1, 8'h00, 8'h5A, 0, 0, 1);   // gap holds
    cyc(1, 0, 0, 1, 8'h81, 8'h35, 0, 0, 2);
    cyc(0, 0, 1, 1, 8'h00, 8'h35, 0, 0, 2);   // FINISH -> CHECK
    cyc(0, 0, 0, 1, 8'h00, 8'h35, 1, 1, 2);   // result registered
    cyc(1, 1, 1, 1, 8'hFF, 8'h35, 1, 1, 2);   // RESULT ignores OUT/POLY/FINISH
    cyc(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);   // restart clears

    // Run 2: FINISH coincident with the last word.
    cyc(1, 0, 0, 1, 8'h5A, 8'h5A, 0, 0, 1);
    cyc(1, 0, 1, 1, 8'h81, 8'h35, 0, 0, 2);
    cyc(0, 0, 0, 1, 8'h00, 8'h35, 1, 1, 2);
    cyc(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Run 3: polynomial select.
    cyc(1, 0, 0, 1, 8'h80, 8'h80, 0, 0, 1);
    cyc(1, 0, 0, 1, 8'h00, 8'h1D, 0, 0, 2);   // POLY_A
    cyc(1, 0, 0, 1, 8'hBA, 8'h80, 0, 0, 3);
    cyc(1, 1, 0, 1, 8'h00, 8'h2B, 0, 0, 4);   // POLY_B
    cyc(0, 0, 1, 1, 8'h00, 8'h2B, 0, 0, 4);
    cyc(0, 0, 0, 1, 8'h00, 8'h2B, 1, 0, 4);
    cyc(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Run 4: three words, signature equals dut_a golden, count differs.
    cyc(1, 0, 0, 1, 8'h5A, 8'h5A, 0, 0, 1);
    cyc(1, 0, 0, 1, 8'h81, 8'h35, 0, 0, 2);
    cyc(1, 0, 0, 1, 8'h5F, 8'h35, 0, 0, 3);
    cyc(0, 0, 1, 1, 8'h00, 8'h35, 0, 0, 3);
    cyc(0, 0, 0, 1, 8'h00, 8'h35, 1, !CNT_EN, 3);
    cyc(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Run 5: zero-vector run straight from IDLE.
    cyc(0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0);
    cyc(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0);
    cyc(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Run 6: reset mid-COMPACT clears asynchronously before the next edge.
    cyc(1, 0, 0, 1, 8'h3C, 8'h3C, 0, 0, 1);
    cyc(0, 0, 0, 1, 8'h00, 8'h3C, 0, 0, 1);
    #6;
    reset = 1'b1;
    #1;
    push_exp(8'h00, 0, 0, 0);
    -> mon_ev;
    #1;
    cyc(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    reset = 1'b0;
    // Back in IDLE from SIG_INIT: the first word lands directly.
    cyc(1, 0, 0, 1, 8'h5A, 8'h5A, 0, 0, 1);
    cyc(0, 0, 0, 1, 8'h00, 8'h5A, 0, 0, 1);

    repeat (3) @(posedge clk);
    vectors++;
    if (qa.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", qa.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
